// File: rtl/dac_drv_pkg.sv
// Shared types, widths and helpers for the segmented DAC driver sequencer.
package dac_drv_pkg;

  localparam int unsigned NBIN       = 7;
  localparam int unsigned NTHERM     = 17;
  localparam int unsigned CODE_W     = 12;
  localparam int unsigned N_W        = 5;
  localparam int unsigned PTR_W      = 5;
  localparam int unsigned CODE_MAX   = NTHERM * (2 ** NBIN) + (2 ** NBIN) - 1;
  localparam int unsigned PIPE_DEPTH = 3;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_WAKE,
    ST_RUN,
    ST_DRAIN,
    ST_FAULT
  } state_e;

  // Stage 1 payload: split code plus the rotation start captured at acceptance.
  typedef struct packed {
    logic [N_W-1:0]   n;
    logic [NBIN-1:0]  b;
    logic [PTR_W-1:0] ptr;
    logic             dem;
  } s1_t;

  typedef struct packed {
    logic [NBIN-1:0]   bin;
    logic [NTHERM-1:0] therm;
  } drv_t;

  localparam s1_t                S1_ZERO      = '0;
  localparam drv_t               DRV_ZERO     = '0;
  localparam logic [NBIN-1:0]    DATAINB_RST  = '1;
  localparam logic [NTHERM-1:0]  DATATHERMB_RST = '1;

  // a + n mod NTHERM; a < NTHERM and n <= NTHERM so one subtraction suffices.
  function automatic logic [PTR_W-1:0] mod_add(input logic [PTR_W-1:0] a,
                                               input logic [N_W-1:0]   n);
    logic [PTR_W:0] sum;
    sum = (PTR_W+1)'(a) + (PTR_W+1)'(n);
    if (sum >= (PTR_W+1)'(NTHERM)) begin
      sum = sum - (PTR_W+1)'(NTHERM);
    end
    return PTR_W'(sum);
  endfunction

endpackage

// File: rtl/therm_rotator.sv
// Builds the thermometer mask: n consecutive elements starting at ptr (or 0), wrapping.
module therm_rotator
  import dac_drv_pkg::*;
(
  input  logic [N_W-1:0]    n,
  input  logic [PTR_W-1:0]  ptr,
  input  logic              dem_en,
  output logic [NTHERM-1:0] mask_c
);

  logic [PTR_W-1:0] start;

  assign start = dem_en ? ptr : '0;

  always_comb begin : p_mask
    int off;
    off    = 0;
    mask_c = '0;
    for (int i = 0; i < int'(NTHERM); i++) begin
      off = i - int'(start);
      if (off < 0) begin
        off = off + int'(NTHERM);
      end
      mask_c[i] = (off < int'(n));
    end
  end

endmodule

// File: rtl/dac_drv_sequencer.sv
// Power sequencing, code split/saturation and DWA pipeline for the DAC driver cell.
module dac_drv_sequencer
  import dac_drv_pkg::*;
#(
  parameter int unsigned T_WAKE  = 16,
  parameter int unsigned T_DRAIN = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              supply_ok,
  input  logic              dem_en,
  input  logic [CODE_W-1:0] code,
  input  logic              code_valid,
  output logic              code_ready,
  output logic              pdb,
  output logic [NBIN-1:0]   datain,
  output logic [NBIN-1:0]   datainb,
  output logic [NTHERM-1:0] datatherm,
  output logic [NTHERM-1:0] datathermb,
  output logic              busy,
  output logic              fault
);

  // DRAIN covers the in-flight sample plus T_DRAIN cycles of zero code.
  localparam int unsigned DRAIN_CYC = PIPE_DEPTH + T_DRAIN;
  localparam int unsigned CNT_W     = $clog2(T_WAKE + DRAIN_CYC + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                pdb_q, pdb_d;
  logic                code_ready_q, code_ready_d;
  logic                busy_q, busy_d;
  logic                fault_q, fault_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  s1_t                 s1_q, s1_d;
  drv_t                s2_q, s2_d;
  drv_t                drv_q, drv_d;
  logic [NBIN-1:0]     datainb_q, datainb_d;
  logic [NTHERM-1:0]   datathermb_q, datathermb_d;

  logic                accept;
  logic [CODE_W-1:0]   code_sat;
  logic [N_W-1:0]      code_n;
  logic [NTHERM-1:0]   rot_mask;

  therm_rotator u_rot (
    .n      (s1_q.n),
    .ptr    (s1_q.ptr),
    .dem_en (s1_q.dem),
    .mask_c (rot_mask)
  );

  // Next state; a supply drop outside OFF overrides every other transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_OFF: begin
        if (en && supply_ok && !fault_q) begin
          state_d = ST_WAKE;
          cnt_d   = '0;
        end
      end
      ST_WAKE: begin
        if (!en) begin
          state_d = ST_OFF;
        end else if (cnt_q == CNT_W'(T_WAKE - 1)) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!en) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CNT_W'(DRAIN_CYC - 1)) begin
          state_d = ST_OFF;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FAULT: begin
        if (!en) begin
          state_d = ST_OFF;
        end
      end
      default: state_d = ST_OFF;
    endcase
    if ((state_q != ST_OFF) && !supply_ok) begin
      state_d = ST_FAULT;
    end
  end

  // Data pipeline: stage 1 split/ptr, stage 2 mask, then the output register.
  always_comb begin
    accept   = code_valid && code_ready_q;
    code_sat = (code > CODE_W'(CODE_MAX)) ? CODE_W'(CODE_MAX) : code;
    code_n   = code_sat[CODE_W-1:NBIN];
    s1_d     = s1_q;
    ptr_d    = ptr_q;
    if (state_q != ST_RUN) begin
      s1_d = S1_ZERO;
    end else if (accept) begin
      s1_d.n   = code_n;
      s1_d.b   = code_sat[NBIN-1:0];
      s1_d.ptr = ptr_q;
      s1_d.dem = dem_en;
      if (dem_en) begin
        ptr_d = mod_add(ptr_q, code_n);
      end
    end
    s2_d.bin   = s1_q.b;
    s2_d.therm = rot_mask;
    drv_d      = s2_q;
    if (state_d == ST_FAULT) begin
      s1_d  = S1_ZERO;
      s2_d  = DRV_ZERO;
      drv_d = DRV_ZERO;
      ptr_d = '0;
    end
    datainb_d    = ~drv_d.bin;
    datathermb_d = ~drv_d.therm;
    pdb_d        = (state_d == ST_WAKE) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
    code_ready_d = (state_d == ST_RUN);
    busy_d       = (state_d != ST_OFF);
    fault_d      = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_OFF;
      cnt_q        <= '0;
      pdb_q        <= 1'b0;
      code_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
      ptr_q        <= '0;
      s1_q         <= S1_ZERO;
      s2_q         <= DRV_ZERO;
      drv_q        <= DRV_ZERO;
      datainb_q    <= DATAINB_RST;
      datathermb_q <= DATATHERMB_RST;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pdb_q        <= pdb_d;
      code_ready_q <= code_ready_d;
      busy_q       <= busy_d;
      fault_q      <= fault_d;
      ptr_q        <= ptr_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      drv_q        <= drv_d;
      datainb_q    <= datainb_d;
      datathermb_q <= datathermb_d;
    end
  end

  assign code_ready = code_ready_q;
  assign pdb        = pdb_q;
  assign datain     = drv_q.bin;
  assign datainb    = datainb_q;
  assign datatherm  = drv_q.therm;
  assign datathermb = datathermb_q;
  assign busy       = busy_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_dac_drv_sequencer.sv
// Scoreboard bench: stimulus queues cycle-stamped expectations, a negedge monitor checks them.
module tb_dac_drv_sequencer;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        supply_ok;
  logic        dem_en;
  logic [11:0] code;
  logic        code_valid;
  logic        code_ready;
  logic        pdb;
  logic [6:0]  datain;
  logic [6:0]  datainb;
  logic [16:0] datatherm;
  logic [16:0] datathermb;
  logic        busy;
  logic        fault;

  dac_drv_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .supply_ok  (supply_ok),
    .dem_en     (dem_en),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .pdb        (pdb),
    .datain     (datain),
    .datainb    (datainb),
    .datatherm  (datatherm),
    .datathermb (datathermb),
    .busy       (busy),
    .fault      (fault)
  );

  typedef struct {
    int          cyc;
    logic        pdb;
    logic        rdy;
    logic        busy;
    logic        flt;
    logic [6:0]  din;
    logic [16:0] dth;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    cyc;
  int    n_vec;
  int    n_miss;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every expectation stamped with the current edge count is compared here.
  always @(negedge clk) begin
    exp_t  e;
    string t;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_vec = n_vec + 1;
      if (e.cyc != cyc || pdb !== e.pdb || code_ready !== e.rdy || busy !== e.busy ||
          fault !== e.flt || datain !== e.din || datainb !== ~e.din ||
          datatherm !== e.dth || datathermb !== ~e.dth) begin
        n_miss = n_miss + 1;
        $display("FAIL %s cyc=%0d: got pdb=%b rdy=%b busy=%b flt=%b din=%h dinb=%h dth=%h dthb=%h; want cyc=%0d pdb=%b rdy=%b busy=%b flt=%b din=%h dinb=%h dth=%h dthb=%h",
                 t, cyc, pdb, code_ready, busy, fault, datain, datainb, datatherm, datathermb,
                 e.cyc, e.pdb, e.rdy, e.busy, e.flt, e.din, ~e.din, e.dth, ~e.dth);
      end
    end
  end

  task automatic push(input int c, input string tag, input logic p, input logic r,
                      input logic b, input logic f, input logic [6:0] din,
                      input logic [16:0] dth);
    exp_t e;
    e.cyc  = c;
    e.pdb  = p;
    e.rdy  = r;
    e.busy = b;
    e.flt  = f;
    e.din  = din;
    e.dth  = dth;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // From OFF: pdb after the next edge, code_ready exactly 16 cycles after that.
  task automatic do_wake();
    int c0;
    c0 = cyc;
    en = 1'b1;
    supply_ok = 1'b1;
    for (int k = 1; k <= 16; k++) push(c0 + k, "wake", 1, 0, 1, 0, 7'h00, 17'h00000);
    push(c0 + 17, "run_entry", 1, 1, 1, 0, 7'h00, 17'h00000);
    step(17);
  endtask

  // One accepted sample; it reaches the outputs three edges from now.
  task automatic send(input logic [11:0] c, input logic dem, input logic [6:0] din,
                      input logic [16:0] dth, input string tag);
    code       = c;
    code_valid = 1'b1;
    dem_en     = dem;
    push(cyc + 3, tag, 1, 1, 1, 0, din, dth);
    step(1);
  endtask

  initial begin
    int c;
    n_vec      = 0;
    n_miss     = 0;
    rst_n      = 1'b0;
    en         = 1'b0;
    supply_ok  = 1'b1;
    dem_en     = 1'b0;
    code       = 12'd0;
    code_valid = 1'b0;
    step(3);
    push(cyc, "reset_state", 0, 0, 0, 0, 7'h00, 17'h00000);
    step(1);
    rst_n = 1'b1;
    step(1);

    do_wake();

    // Fixed fill, latency and saturation.
    push(cyc + 1, "latency0", 1, 1, 1, 0, 7'h00, 17'h00000);
    push(cyc + 2, "latency1", 1, 1, 1, 0, 7'h00, 17'h00000);
    send(12'd1023, 1'b0, 7'h7F, 17'h0007F, "fill_1023");
    send(12'd4000, 1'b0, 7'h7F, 17'h1FFFF, "sat_4000");
    send(12'd130,  1'b0, 7'h02, 17'h00001, "fill_130");
    send(12'd0,    1'b0, 7'h00, 17'h00000, "fill_0");
    code_valid = 1'b0;
    step(3);

    // DWA rotation, including wrap and the n=17 pointer hold.
    send(12'd1280, 1'b1, 7'h00, 17'h003FF, "dwa_1280_a");
    send(12'd1280, 1'b1, 7'h00, 17'h1FC07, "dwa_1280_b");
    send(12'd128,  1'b1, 7'h00, 17'h00008, "dwa_ptr3");
    send(12'd2304, 1'b1, 7'h7F, 17'h1FFFF, "dwa_sat_full");
    send(12'd200,  1'b1, 7'h48, 17'h00010, "dwa_ptr4");
    code_valid = 1'b0;
    step(3);

    // Asynchronous reset in RUN.
    c = cyc;
    push(c,     "arst0", 0, 0, 0, 0, 7'h00, 17'h00000);
    push(c + 1, "arst1", 0, 0, 0, 0, 7'h00, 17'h00000);
    push(c + 2, "arst2", 0, 0, 0, 0, 7'h00, 17'h00000);
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    do_wake();
    send(12'd300, 1'b1, 7'h2C, 17'h00003, "dwa_after_rst");
    code_valid = 1'b0;
    step(3);

    // Supply fault in RUN; recovery needs en low.
    c = cyc;
    push(c + 1, "fault_entry", 0, 0, 1, 1, 7'h00, 17'h00000);
    push(c + 2, "fault_hold0", 0, 0, 1, 1, 7'h00, 17'h00000);
    push(c + 3, "fault_hold1", 0, 0, 1, 1, 7'h00, 17'h00000);
    push(c + 4, "fault_clear", 0, 0, 0, 0, 7'h00, 17'h00000);
    supply_ok = 1'b0;
    step(1);
    supply_ok = 1'b1;
    step(2);
    en = 1'b0;
    step(1);

    // WAKE aborted by en falling.
    c = cyc;
    en = 1'b1;
    for (int k = 1; k <= 3; k++) push(c + k, "wake_abort", 1, 0, 1, 0, 7'h00, 17'h00000);
    push(c + 4, "wake_off", 0, 0, 0, 0, 7'h00, 17'h00000);
    step(3);
    en = 1'b0;
    step(1);

    do_wake();
    send(12'd128, 1'b1, 7'h00, 17'h00001, "dwa_after_fault");
    code_valid = 1'b0;
    step(3);

    // en falls with a full-scale sample in flight.
    c = cyc;
    push(c + 1, "drain_prev0", 1, 0, 1, 0, 7'h00, 17'h00001);
    push(c + 2, "drain_prev1", 1, 0, 1, 0, 7'h00, 17'h00001);
    push(c + 3, "drain_flight", 1, 0, 1, 0, 7'h7F, 17'h1FFFF);
    push(c + 4, "drain_zero0", 1, 0, 1, 0, 7'h00, 17'h00000);
    push(c + 5, "drain_zero1", 1, 0, 1, 0, 7'h00, 17'h00000);
    push(c + 6, "drain_off", 0, 0, 0, 0, 7'h00, 17'h00000);
    code       = 12'd2303;
    code_valid = 1'b1;
    dem_en     = 1'b1;
    en         = 1'b0;
    step(1);
    code_valid = 1'b0;

    for (int i = 0; i < 50 && exp_q.size() > 0; i++) step(1);
    if (exp_q.size() > 0) begin
      n_vec  = n_vec + 1;
      n_miss = n_miss + 1;
      $display("FAIL drain_timeout: %0d expectations left, want 0", exp_q.size());
    end
    step(1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
